// File: rtl/axi_arbiter_rr.sv
// Address-channel arbiter: grants one of NUM_MASTERS requesters at a time and
// holds the grant until the owner's ARVALID/ARREADY handshake completes.
module axi_arbiter_rr #(
  parameter  int NUM_MASTERS = 4,
  parameter  int ARB_MODE    = 0,
  localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_MASTERS-1:0] req_valid_i,
  input  logic                   ready_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   busy_o,
  output logic                   proto_err_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       owner_reg;
  logic [IDX_W-1:0]       ptr_reg;
  logic                   proto_err_reg;

  logic [NUM_MASTERS-1:0] owner_onehot;
  logic                   owner_req;
  logic [IDX_W-1:0]       ptr_inc;
  logic [NUM_MASTERS-1:0] arb_req;
  logic [IDX_W-1:0]       arb_ptr;
  logic                   win_valid;
  logic [IDX_W-1:0]       win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
      assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
      assign grant_o[gi]      = (state_reg == GRANTED) && owner_onehot[gi];
    end
  endgenerate

  assign owner_req = req_valid_i[owner_reg];
  assign ptr_inc   = (owner_reg == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_reg + 1'b1;

  // While granted, the only arbitration that matters is the handshake
  // re-arbitration: owner excluded, pointer already advanced past it.
  assign arb_req = (state_reg == GRANTED) ? (req_valid_i & ~owner_onehot) : req_valid_i;
  assign arb_ptr = (state_reg == GRANTED) ? ptr_inc : ptr_reg;

  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (ARB_MODE == 1) begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        cand_idx = IDX_W'(k);
        if (arb_req[cand_idx]) begin
          win_valid = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        cand = int'(arb_ptr) + k;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
        cand_idx = IDX_W'(cand);
        if (!win_valid && arb_req[cand_idx]) begin
          win_valid = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      ptr_reg       <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      proto_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg <= GRANTED;
            owner_reg <= win_idx;
          end
        end
        GRANTED: begin
          if (!owner_req) begin
            // Owner withdrew before its handshake: flag it, keep the pointer.
            proto_err_reg <= 1'b1;
            state_reg     <= IDLE;
            owner_reg     <= '0;
          end else if (ready_i) begin
            ptr_reg <= ptr_inc;
            if (win_valid) begin
              owner_reg <= win_idx;
            end else begin
              state_reg <= IDLE;
              owner_reg <= '0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          owner_reg <= '0;
        end
      endcase
    end
  end

  assign grant_idx_o = owner_reg;
  assign busy_o      = (state_reg == GRANTED);
  assign proto_err_o = proto_err_reg;

endmodule

// File: tb/tb_axi_arbiter_rr.sv
// Directed bench for axi_arbiter_rr: one round-robin and one fixed-priority
// instance, each driven by its own request/ready inputs.
module tb_axi_arbiter_rr;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_rr, req_fp;
  logic       rdy_rr, rdy_fp;
  logic [3:0] grant_rr, grant_fp;
  logic [1:0] idx_rr, idx_fp;
  logic       busy_rr, busy_fp;
  logic       perr_rr, perr_fp;

  int tests = 0;
  int fails = 0;

  axi_arbiter_rr #(.NUM_MASTERS(4), .ARB_MODE(0)) u_rr (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_rr),
    .ready_i     (rdy_rr),
    .grant_o     (grant_rr),
    .grant_idx_o (idx_rr),
    .busy_o      (busy_rr),
    .proto_err_o (perr_rr)
  );

  axi_arbiter_rr #(.NUM_MASTERS(4), .ARB_MODE(1)) u_fp (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_fp),
    .ready_i     (rdy_fp),
    .grant_o     (grant_fp),
    .grant_idx_o (idx_fp),
    .busy_o      (busy_fp),
    .proto_err_o (perr_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks busy, index, one-hot grant and error pulse together.
  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                         input logic b, input logic p,
                         input logic eb, input logic [1:0] ei, input logic ep);
    logic [3:0] eg;
    eg = eb ? (4'b0001 << ei) : 4'b0000;
    chk({tag, ".busy"}, 32'(b), 32'(eb));
    chk({tag, ".idx"}, 32'(i), eb ? 32'(ei) : 32'd0);
    chk({tag, ".grant"}, 32'(g), 32'(eg));
    chk({tag, ".perr"}, 32'(p), 32'(ep));
    $display("[TB] %s grant=%b idx=%0d busy=%0d perr=%0d", tag, g, i, b, p);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    req_rr = 4'b0000; rdy_rr = 1'b0;
    req_fp = 4'b0000; rdy_fp = 1'b0;
    step(); step();
    chk_out("reset_rr", grant_rr, idx_rr, busy_rr, perr_rr, 1'b0, 2'd0, 1'b0);
    chk_out("reset_fp", grant_fp, idx_fp, busy_fp, perr_fp, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Idle with no requests, ready ignored
    rdy_rr = 1'b1;
    step();
    chk_out("idle_noreq", grant_rr, idx_rr, busy_rr, perr_rr, 1'b0, 2'd0, 1'b0);

    // Round-robin fairness: 0,1,2,3,0 back to back
    req_rr = 4'b1111; rdy_rr = 1'b1;
    step(); chk_out("rr_seq0", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd0, 1'b0);
    step(); chk_out("rr_seq1", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd1, 1'b0);
    step(); chk_out("rr_seq2", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd2, 1'b0);
    step(); chk_out("rr_seq3", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd3, 1'b0);
    step(); chk_out("rr_seq4", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd0, 1'b0);

    // Owner hold: reach owner 2, stall 5 cycles, then advance to 3
    step(); chk_out("rr_to1", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd1, 1'b0);
    step(); chk_out("rr_to2", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd2, 1'b0);
    rdy_rr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_grant", 32'(grant_rr), 32'h4);
    end
    rdy_rr = 1'b1;
    step(); chk_out("hold_next", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd3, 1'b0);

    // Protocol error: owner 0 drops its request while stalled (ptr is 0)
    step(); chk_out("perr_own0", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd0, 1'b0);
    rdy_rr = 1'b0; req_rr = 4'b1110;
    step(); chk_out("perr_pulse", grant_rr, idx_rr, busy_rr, perr_rr, 1'b0, 2'd0, 1'b1);
    req_rr = 4'b1111;
    step(); chk_out("perr_ptr", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd0, 1'b0);

    // Async reset mid-grant while owner is 1 (ptr would be 1)
    rdy_rr = 1'b1;
    step(); chk_out("ar_own1", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd1, 1'b0);
    rdy_rr = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_out("ar_async", grant_rr, idx_rr, busy_rr, perr_rr, 1'b0, 2'd0, 1'b0);
    req_rr = 4'b0011; rdy_rr = 1'b1;
    step(); chk_out("ar_held", grant_rr, idx_rr, busy_rr, perr_rr, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step(); chk_out("ar_first", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd0, 1'b0);

    // Single requester: handshake with no other candidate returns to IDLE
    req_rr = 4'b0001;
    step(); chk_out("single_idle0", grant_rr, idx_rr, busy_rr, perr_rr, 1'b0, 2'd0, 1'b0);
    req_rr = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      step(); chk_out("single_g3", grant_rr, idx_rr, busy_rr, perr_rr, 1'b1, 2'd3, 1'b0);
      step(); chk_out("single_idle", grant_rr, idx_rr, busy_rr, perr_rr, 1'b0, 2'd0, 1'b0);
    end

    // Fixed priority: 1010 alternates 1,3,1,3
    chk_out("fp_idle", grant_fp, idx_fp, busy_fp, perr_fp, 1'b0, 2'd0, 1'b0);
    req_fp = 4'b1010; rdy_fp = 1'b1;
    step(); chk_out("fp_seq0", grant_fp, idx_fp, busy_fp, perr_fp, 1'b1, 2'd1, 1'b0);
    step(); chk_out("fp_seq1", grant_fp, idx_fp, busy_fp, perr_fp, 1'b1, 2'd3, 1'b0);
    step(); chk_out("fp_seq2", grant_fp, idx_fp, busy_fp, perr_fp, 1'b1, 2'd1, 1'b0);
    step(); chk_out("fp_seq3", grant_fp, idx_fp, busy_fp, perr_fp, 1'b1, 2'd3, 1'b0);
    // All requesting: lowest index wins, no pointer rotation
    req_fp = 4'b1111;
    step(); chk_out("fp_all0", grant_fp, idx_fp, busy_fp, perr_fp, 1'b1, 2'd0, 1'b0);
    step(); chk_out("fp_all1", grant_fp, idx_fp, busy_fp, perr_fp, 1'b1, 2'd1, 1'b0);
    step(); chk_out("fp_all2", grant_fp, idx_fp, busy_fp, perr_fp, 1'b1, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_arbiter_rr.md
AXI_ARBITER_RR -- requirements
Module: axi_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters (legal 2..16).
REQ-002 SHALL have parameter ARB_MODE, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-003 SHALL define localparam IDX_W = max(1, ceil(log2(NUM_MASTERS))).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid_i  input  NUM_MASTERS  per-master ARVALID; bit i belongs to master i.
REQ-007 SHALL have port ready_i  input  1  slave ARREADY.
REQ-008 SHALL have port grant_o  output  NUM_MASTERS  one-hot grant, all-zero when no owner.
REQ-009 SHALL have port grant_idx_o  output  IDX_W  index of current owner; 0 when no owner.
REQ-010 SHALL have port busy_o  output  1  high while a grant is held.
REQ-011 SHALL have port proto_err_o  output  1  one-cycle pulse on owner protocol violation.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no owner) and GRANTED (one owner held).
REQ-013 SHALL register all outputs; grant_o, grant_idx_o and busy_o SHALL derive only from state and owner registers.
REQ-014 SHALL, in IDLE with any req_valid_i bit high at edge t, enter GRANTED at t+1 with the arbitration winner as owner (one-cycle grant latency).
REQ-015 SHALL, in IDLE with req_valid_i all zero, remain in IDLE.
REQ-016 SHALL, in round-robin mode, select as winner the first requesting index at or above priority pointer ptr, scanning upward and wrapping from NUM_MASTERS-1 to 0.
REQ-017 SHALL, in fixed-priority mode, select the lowest requesting index and never use ptr.
REQ-018 SHALL hold the owner unchanged in GRANTED while req_valid_i[owner]=1 and ready_i=0, regardless of other requests.
REQ-019 SHALL treat req_valid_i[owner]=1 and ready_i=1 in GRANTED as a handshake.
REQ-020 SHALL, on handshake, set ptr to (owner+1) mod NUM_MASTERS, wrapping at NUM_MASTERS-1.
REQ-021 SHALL, on handshake, re-arbitrate in the same cycle over req_valid_i with the owner bit masked, using the updated ptr; if any candidate exists, stay GRANTED with the new owner at the next edge (no idle bubble).
REQ-022 SHALL, on handshake with no other candidate, return to IDLE; the previous owner re-requests through IDLE.
REQ-023 SHALL, when req_valid_i[owner] falls to 0 in GRANTED without a handshake, pulse proto_err_o for one cycle, leave ptr unchanged and return to IDLE.
REQ-024 SHALL keep grant_o exactly one-hot in GRANTED and zero in IDLE; grant_idx_o SHALL always match grant_o.
REQ-025 SHALL ignore ready_i while in IDLE.

Reset
REQ-026 SHALL, on rst_ni low, immediately (asynchronously) force state=IDLE, ptr=0, grant_o=0, grant_idx_o=0, busy_o=0, proto_err_o=0.
REQ-027 SHALL discard any in-progress grant when reset asserts mid-transaction, and SHALL take no handshake during reset.
REQ-028 SHALL, after rst_ni rises, sample requests from the first rising edge onward.

Verification (NUM_MASTERS=4)
REQ-029 SHALL cover round-robin fairness: ARB_MODE=0, req_valid_i=4'b1111 held, ready_i=1 -> grant_idx_o sequence 0,1,2,3,0 on consecutive cycles, no IDLE cycles.
REQ-030 SHALL cover owner hold: owner=2 with ready_i=0 for 5 cycles while req_valid_i=4'b1111 -> grant_o stays 4'b0100; ready_i=1 -> next owner is 3.
REQ-031 SHALL cover fixed priority: ARB_MODE=1, req_valid_i=4'b1010 held, ready_i=1 -> owners 1,3,1,3.
REQ-032 SHALL cover the protocol error: owner 0 drops req_valid_i[0] with ready_i=0 -> proto_err_o=1 for one cycle, busy_o=0 next cycle, ptr unchanged.
REQ-033 SHALL cover async reset mid-grant: rst_ni low between edges while owner=1 -> grant_o=0 and busy_o=0 before the next edge; the first grant after release goes to index 0 when req_valid_i=4'b0011.
REQ-034 SHALL cover the single requester: req_valid_i=4'b1000 pulsed each cycle after handshake -> alternating GRANTED/IDLE; grant_idx_o=3 whenever busy_o=1.
